// File: rtl/load_align_unit_pkg.sv
// rtl/load_align_unit_pkg.sv - shared opcodes, bus size codes, FSM states and FIFO entry layout
package load_align_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lau_state_e;

  // Parameter-independent part of a FIFO entry; the lane offset and tag
  // live in parallel arrays sized by DATA_W and TAG_W.
  typedef struct packed {
    logic [5:0] op;
    logic       kill;
  } fifo_meta_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if ((op == OP_LH) || (op == OP_LHU)) bad = lo[0];
    else if (op == OP_LW)                bad = |lo;
    return bad;
  endfunction

  function automatic mem_size_e load_size(input logic [5:0] op);
    mem_size_e sz;
    sz = MEM_SIZE_BYTE;
    if ((op == OP_LH) || (op == OP_LHU)) sz = MEM_SIZE_HALF;
    else if (op == OP_LW)                sz = MEM_SIZE_WORD;
    return sz;
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - request, bus and result signals of the load align unit
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [31:0]       in_addr;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [1:0]        mem_size;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [31:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              adel_valid;
  logic [31:0]       adel_badvaddr;
  logic [TAG_W-1:0]  adel_tag;

  // Unit side
  modport slave (
    input  in_valid, in_op, in_addr, in_tag, flush,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output in_ready, mem_req, mem_addr, mem_size,
    output out_valid, out_data, out_tag,
    output adel_valid, adel_badvaddr, adel_tag
  );

  // Pipeline / memory side
  modport master (
    output in_valid, in_op, in_addr, in_tag, flush,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  in_ready, mem_req, mem_addr, mem_size,
    input  out_valid, out_data, out_tag,
    input  adel_valid, adel_badvaddr, adel_tag
  );
endinterface

// File: rtl/load_data_format.sv
// rtl/load_data_format.sv - selects and extends the addressed lanes of a returned bus word
module load_data_format
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [5:0]        op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] rdata,
  output logic [31:0]       data
);

  logic [31:0] lanes;

  // Shift the addressed byte lane down to bit 0
  always_comb begin
    lanes = 32'(rdata >> {offset, 3'b000});
  end

  // Sign/zero extension by opcode; non-loads never reach here with kill=0
  always_comb begin
    data = '0;
    case (op)
      OP_LB:   data = {{24{lanes[7]}}, lanes[7:0]};
      OP_LBU:  data = {24'b0, lanes[7:0]};
      OP_LH:   data = {{16{lanes[15]}}, lanes[15:0]};
      OP_LHU:  data = {16'b0, lanes[15:0]};
      OP_LW:   data = lanes;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load request alignment, bus issue, in-flight tracking and result formatting
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 5
) (
  input logic             clk,
  input logic             resetn,
  load_align_unit_if.slave bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DEPTH = 1 << PTR_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  lau_state_e state, state_next;

  logic             req_q;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic [5:0]       req_op;
  logic [OFF_W-1:0] req_off;
  logic [TAG_W-1:0] req_tag;
  logic             req_kill;

  fifo_meta_t       fifo_meta [DEPTH];
  logic [OFF_W-1:0] fifo_off  [DEPTH];
  logic [TAG_W-1:0] fifo_tag  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             adel_valid_q;
  logic [31:0]      adel_addr_q;
  logic [TAG_W-1:0] adel_tag_q;

  logic        ready, accept, bad_align, take_req, push, pop, deliver;
  logic [31:0] fmt_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready     = (state == ST_IDLE) && (count < CNT_W'(MAX_OUTSTANDING)) && !bus.flush;
  assign accept    = bus.in_valid && ready;
  assign bad_align = is_load(bus.in_op) && is_misaligned(bus.in_op, bus.in_addr[1:0]);
  assign pop       = bus.mem_data_ok && (count != '0);
  // A flush in the same cycle as the pop discards the popped entry too
  assign deliver   = pop && !fifo_meta[rd_ptr].kill && !bus.flush;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // FSM next state; take_req latches an aligned load, push fires on addr_ok
  always_comb begin
    state_next = state;
    take_req   = 1'b0;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_load(bus.in_op) && !bad_align) begin
          state_next = ST_REQ;
          take_req   = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.mem_addr_ok) begin
          state_next = ST_IDLE;
          push       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus request registers, held stable until the bus takes the request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q    <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      req_op   <= '0;
      req_off  <= '0;
      req_tag  <= '0;
      req_kill <= 1'b0;
    end else if (take_req) begin
      req_q    <= 1'b1;
      addr_q   <= {bus.in_addr[31:OFF_W], {OFF_W{1'b0}}};
      size_q   <= load_size(bus.in_op);
      req_op   <= bus.in_op;
      req_off  <= bus.in_addr[OFF_W-1:0];
      req_tag  <= bus.in_tag;
      req_kill <= 1'b0;
    end else if (push) begin
      req_q    <= 1'b0;
    end else if (state == ST_REQ && bus.flush) begin
      req_kill <= 1'b1;
    end
  end

  // In-flight FIFO; flush marks every entry, a push in the flush cycle is born killed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_meta[i] <= '0;
        fifo_off[i]  <= '0;
        fifo_tag[i]  <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) fifo_meta[i].kill <= 1'b1;
      end
      if (push) begin
        fifo_meta[wr_ptr] <= '{op: req_op, kill: req_kill | bus.flush};
        fifo_off[wr_ptr]  <= req_off;
        fifo_tag[wr_ptr]  <= req_tag;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  load_data_format #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_format (
    .op     (fifo_meta[rd_ptr].op),
    .offset (fifo_off[rd_ptr]),
    .rdata  (bus.mem_rdata),
    .data   (fmt_data)
  );

  // Registered one-cycle result and exception pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      adel_valid_q <= 1'b0;
      adel_addr_q  <= '0;
      adel_tag_q   <= '0;
    end else begin
      out_valid_q  <= deliver;
      if (deliver) begin
        out_data_q <= fmt_data;
        out_tag_q  <= fifo_tag[rd_ptr];
      end
      adel_valid_q <= accept && bad_align;
      if (accept && bad_align) begin
        adel_addr_q <= bus.in_addr;
        adel_tag_q  <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready      = ready;
  assign bus.mem_req       = req_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_size      = size_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.adel_valid    = adel_valid_q;
  assign bus.adel_badvaddr = adel_addr_q;
  assign bus.adel_tag      = adel_tag_q;

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed scoreboard bench for load_align_unit at DATA_W 32 and 64
module tb_load_align_unit;
  import load_align_unit_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } res_t;

  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;
  res_t q32[$];
  res_t q64[$];
  res_t qadel[$];

  always #5 clk = ~clk;

  load_align_unit_if #(.DATA_W(32), .TAG_W(5)) b32 ();
  load_align_unit_if #(.DATA_W(64), .TAG_W(5)) b64 ();

  load_align_unit #(.DATA_W(32), .MAX_OUTSTANDING(2), .TAG_W(5)) u_dut32 (
    .clk(clk), .resetn(resetn), .bus(b32));
  load_align_unit #(.DATA_W(64), .MAX_OUTSTANDING(2), .TAG_W(5)) u_dut64 (
    .clk(clk), .resetn(resetn), .bus(b64));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon32
    res_t e;
    if (resetn === 1'b1 && b32.out_valid === 1'b1) begin
      if (q32.size() == 0) check("out32_spurious", b32.out_valid, 1'b0);
      else begin
        e = q32.pop_front();
        check("out32_data", b32.out_data, e.data);
        check("out32_tag", b32.out_tag, e.tag);
      end
    end
    if (resetn === 1'b1 && b32.adel_valid === 1'b1) begin
      if (qadel.size() == 0) check("adel_spurious", b32.adel_valid, 1'b0);
      else begin
        e = qadel.pop_front();
        check("adel_badvaddr", b32.adel_badvaddr, e.data);
        check("adel_tag", b32.adel_tag, e.tag);
      end
    end
  end

  always @(negedge clk) begin : mon64
    res_t e;
    if (resetn === 1'b1 && b64.out_valid === 1'b1) begin
      if (q64.size() == 0) check("out64_spurious", b64.out_valid, 1'b0);
      else begin
        e = q64.pop_front();
        check("out64_data", b64.out_data, e.data);
        check("out64_tag", b64.out_tag, e.tag);
      end
    end
    if (resetn === 1'b1) check("adel64_none", b64.adel_valid, 1'b0);
  end

  task automatic accept32(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] tag);
    int n = 0;
    while (b32.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("accept32_ready", b32.in_ready, 1'b1);
    b32.in_valid = 1'b1; b32.in_op = op; b32.in_addr = addr; b32.in_tag = tag;
    @(negedge clk);
    b32.in_valid = 1'b0;
  endtask

  task automatic addr32(input logic [31:0] exp_addr, input logic [1:0] exp_size);
    int n = 0;
    while (b32.mem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("mem_req", b32.mem_req, 1'b1);
    check("mem_addr", b32.mem_addr, exp_addr);
    check("mem_size", b32.mem_size, exp_size);
    b32.mem_addr_ok = 1'b1;
    @(negedge clk);
    b32.mem_addr_ok = 1'b0;
  endtask

  task automatic data32(input logic [31:0] rdata);
    b32.mem_data_ok = 1'b1; b32.mem_rdata = rdata;
    @(negedge clk);
    b32.mem_data_ok = 1'b0;
  endtask

  task automatic load32(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] tag,
                        input logic [1:0] size, input logic [31:0] rdata, input logic [31:0] exp);
    q32.push_back('{data: exp, tag: tag});
    accept32(op, addr, tag);
    addr32({addr[31:2], 2'b00}, size);
    data32(rdata);
  endtask

  initial begin
    resetn = 1'b0;
    b32.in_valid = 0; b32.in_op = 0; b32.in_addr = 0; b32.in_tag = 0; b32.flush = 0;
    b32.mem_addr_ok = 0; b32.mem_data_ok = 0; b32.mem_rdata = 0;
    b64.in_valid = 0; b64.in_op = 0; b64.in_addr = 0; b64.in_tag = 0; b64.flush = 0;
    b64.mem_addr_ok = 0; b64.mem_data_ok = 0; b64.mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", b32.mem_req, 1'b0);
    check("rst_mem_addr", b32.mem_addr, 32'h0);
    check("rst_out_valid", b32.out_valid, 1'b0);
    check("rst_out_data", b32.out_data, 32'h0);
    check("rst_adel_valid", b32.adel_valid, 1'b0);
    check("rst_mem_req64", b64.mem_req, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", b32.in_ready, 1'b1);

    // LW with addr_ok on first mem_req cycle, data two cycles later
    q32.push_back('{data: 32'h8001_7F02, tag: 5'd3});
    accept32(OP_LW, 32'h0000_0004, 5'd3);
    addr32(32'h0000_0004, 2'd2);
    repeat (2) @(negedge clk);
    data32(32'h8001_7F02);

    // LB / LBU from lane 3; LBU also holds addr_ok back to check request stability
    load32(OP_LB, 32'h0000_0103, 5'd5, 2'd0, 32'h80FF_0000, 32'hFFFF_FF80);
    q32.push_back('{data: 32'h0000_0080, tag: 5'd6});
    accept32(OP_LBU, 32'h0000_0103, 5'd6);
    repeat (2) begin
      check("hold_mem_req", b32.mem_req, 1'b1);
      check("hold_mem_addr", b32.mem_addr, 32'h0000_0100);
      @(negedge clk);
    end
    addr32(32'h0000_0100, 2'd0);
    data32(32'h80FF_0000);

    // Misaligned LH and LW raise AdEL with no bus activity
    qadel.push_back('{data: 32'h0000_0201, tag: 5'd7});
    accept32(OP_LH, 32'h0000_0201, 5'd7);
    check("adel_no_req", b32.mem_req, 1'b0);
    @(negedge clk);
    check("adel_no_req2", b32.mem_req, 1'b0);
    qadel.push_back('{data: 32'h0000_0302, tag: 5'd2});
    accept32(OP_LW, 32'h0000_0302, 5'd2);
    check("adel_lw_no_req", b32.mem_req, 1'b0);

    // Non-load opcode is swallowed silently
    accept32(6'b101011, 32'h0000_0003, 5'd1);
    @(negedge clk);
    check("nonload_no_req", b32.mem_req, 1'b0);
    check("nonload_ready", b32.in_ready, 1'b1);

    // Two outstanding loads fill the FIFO; results in issue order
    q32.push_back('{data: 32'h1111_2222, tag: 5'd8});
    q32.push_back('{data: 32'h0000_ABCD, tag: 5'd9});
    accept32(OP_LW, 32'h0000_0010, 5'd8);
    addr32(32'h0000_0010, 2'd2);
    accept32(OP_LHU, 32'h0000_0022, 5'd9);
    addr32(32'h0000_0020, 2'd1);
    check("full_not_ready", b32.in_ready, 1'b0);
    data32(32'h1111_2222);
    check("ready_after_pop", b32.in_ready, 1'b1);
    data32(32'hABCD_0000);

    // Flush with two entries in flight: both returns discarded
    accept32(OP_LW, 32'h0000_0030, 5'd10);
    addr32(32'h0000_0030, 2'd2);
    accept32(OP_LB, 32'h0000_0031, 5'd11);
    addr32(32'h0000_0030, 2'd0);
    b32.flush = 1'b1;
    #1 check("flush_not_ready", b32.in_ready, 1'b0);
    @(negedge clk);
    b32.flush = 1'b0;
    data32(32'hDEAD_0001);
    data32(32'hDEAD_0002);
    @(negedge clk);
    check("ready_after_flush", b32.in_ready, 1'b1);
    load32(OP_LW, 32'h0000_0040, 5'd12, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Flush while the request is still waiting for addr_ok
    accept32(OP_LB, 32'h0000_0050, 5'd13);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    addr32(32'h0000_0050, 2'd0);
    data32(32'h0000_0077);

    // Flush in the same cycle as data_ok
    accept32(OP_LW, 32'h0000_0060, 5'd15);
    addr32(32'h0000_0060, 2'd2);
    b32.flush = 1'b1;
    data32(32'h5555_6666);
    b32.flush = 1'b0;
    load32(OP_LH, 32'h0000_0056, 5'd14, 2'd1, 32'h8000_1234, 32'hFFFF_8000);

    // 64-bit bus: LHU from lanes 7:6, LW from lanes 7:4
    q64.push_back('{data: 32'h0000_1234, tag: 5'd1});
    q64.push_back('{data: 32'h1234_ABCD, tag: 5'd4});
    check("ready64", b64.in_ready, 1'b1);
    b64.in_valid = 1'b1; b64.in_op = OP_LHU; b64.in_addr = 32'h0000_0106; b64.in_tag = 5'd1;
    @(negedge clk);
    b64.in_valid = 1'b0;
    check("mem_req64", b64.mem_req, 1'b1);
    check("mem_addr64", b64.mem_addr, 32'h0000_0100);
    check("mem_size64", b64.mem_size, 2'd1);
    b64.mem_addr_ok = 1'b1;
    @(negedge clk);
    b64.mem_addr_ok = 1'b0;
    b64.in_valid = 1'b1; b64.in_op = OP_LW; b64.in_addr = 32'h0000_0104; b64.in_tag = 5'd4;
    @(negedge clk);
    b64.in_valid = 1'b0;
    check("mem_addr64_lw", b64.mem_addr, 32'h0000_0100);
    b64.mem_addr_ok = 1'b1;
    @(negedge clk);
    b64.mem_addr_ok = 1'b0;
    b64.mem_data_ok = 1'b1; b64.mem_rdata = 64'h1234_ABCD_0000_0000;
    repeat (2) @(negedge clk);
    b64.mem_data_ok = 1'b0;

    repeat (4) @(negedge clk);
    check("sb32_drained", q32.size(), 0);
    check("sb64_drained", q64.size(), 0);
    check("sbadel_drained", qadel.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised successor to the combinational load byte-select logic in the MEM stage.
- Accepts MIPS load requests (LB/LBU/LH/LHU/LW) and detects misaligned addresses as an AdEL exception.
- Issues word-aligned requests on an SRAM-like bus and tracks up to MAX_OUTSTANDING in-flight loads in an internal FIFO.
- Extracts and extends the addressed byte/halfword/word from the returned bus word. Supports pipeline flush of in-flight loads.

Parameters:
- DATA_W, 32, memory bus width in bits; legal values 32 or 64.
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned loads; legal values 1..4.
- TAG_W, 5, width of the destination-register tag carried alongside each load.
- Derived: OFF_W = log2(DATA_W/8). Number of address bits selecting a byte lane.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  load request present.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  6  MIPS opcode field instr[31:26].
- in_addr  in  32  effective byte address.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  kill all accepted, unreturned loads.
- mem_req  out  1  bus request.
- mem_addr  out  32  in_addr with low OFF_W bits cleared.
- mem_size  out  2  0=byte, 1=half, 2=word.
- mem_addr_ok  in  1  bus accepted request.
- mem_data_ok  in  1  bus returns data, in request order.
- mem_rdata  in  DATA_W  returned bus word.
- out_valid  out  1  one-cycle pulse: formatted result.
- out_data  out  32  extended load result.
- out_tag  out  TAG_W  tag of result.
- adel_valid  out  1  one-cycle pulse: alignment exception.
- adel_badvaddr  out  32  faulting address.
- adel_tag  out  TAG_W  tag of faulting load.

Behaviour:
- Reset values: every output 0; FIFO empty; state IDLE. Reset mid-transaction drops everything, including a pending mem_req.
- Accept condition:
  - in_valid && in_ready, where in_ready = (state==IDLE) && (fifo_count < MAX_OUTSTANDING) && !flush.
  - Any opcode outside the five loads is accepted, produces no output, and raises no exception.
- Alignment rules:
  - LH/LHU require addr[0]==0.
  - LW requires addr[1:0]==0.
  - LB/LBU are never misaligned.
- Misaligned load:
  - No bus request and no FIFO entry.
  - Next cycle: adel_valid=1, adel_badvaddr=in_addr, adel_tag=in_tag.
- Aligned load:
  - Next cycle, state moves IDLE->REQ.
  - mem_req=1, mem_addr, and mem_size are registered and held stable until mem_addr_ok.
- REQ state:
  - On mem_req && mem_addr_ok, push {op, addr[OFF_W-1:0], tag, kill} to the FIFO and return to IDLE.
  - mem_req never deasserts without addr_ok.
- Response:
  - mem_data_ok pops the FIFO head.
  - If the head's kill=0: next cycle out_valid=1 with out_data and out_tag.
  - If kill=1: the entry is silently discarded.
  - mem_data_ok with an empty FIFO is ignored.
- Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- Formatting (little-endian lanes):
  - Byte lane k = mem_rdata[8k+7:8k], with k = addr[OFF_W-1:0].
  - LB: sign-extend lane k. LBU: zero-extend lane k.
  - LH/LHU: lanes k+1:k, sign- or zero-extended respectively.
  - LW: lanes k+3:k.
  - Example, DATA_W=32, addr=2'b11: LB takes rdata[31:24].
- Flush:
  - Sets kill=1 on every FIFO entry that cycle.
  - In REQ state, also marks the pending request killed. The request is still held until addr_ok, then pushed with kill=1.
  - A result already registered for out_valid in that cycle still appears.
- Simultaneous flush and data_ok: the popped entry is discarded.

Decomposition:
- Shared package/header holds:
  - opcode constants LB=6'b100000, LH=6'b100001, LW=6'b100011, LBU=6'b100100, LHU=6'b100101;
  - mem_size encodings;
  - the FIFO entry field layout.
- One natural sub-module: load_data_format. It is purely combinational and takes (op, offset, rdata), producing data.

Test Plan:
- LW 0x00000004, addr_ok same cycle, data_ok 2 cycles later with rdata=0x8001_7F02 -> out_data=0x80017F02, correct tag, no adel.
- LB addr 0x..03 then LBU addr 0x..03, each with rdata=0x80FF_0000 -> results 0xFFFFFF80 then 0x00000080.
- LH addr 0x..01 -> adel_valid pulse with badvaddr=0x..01; mem_req stays 0; no out_valid.
- Two loads accepted with data_ok withheld (MAX_OUTSTANDING=2) -> in_ready=0. First data_ok -> in_ready returns 1. Results appear in issue order.
- Flush with two entries in flight, then two data_ok -> zero out_valid pulses. A subsequent load completes normally.
- DATA_W=64: LHU addr 0x..06 with rdata=0x1234_ABCD_0000_0000 -> out_data=0x00001234.
